// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: core data-port plus TX stream and halt signals for dmem_mmio.
//   we, a, wd, tx_ready   : driven by the master (core / bench)
//   rd, tx_valid, tx_data,
//   halt, halt_code       : driven by the slave (dmem_mmio)
interface dmem_mmio_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] halt_code;

  modport master (
    output we, a, wd, tx_ready,
    input  rd, tx_valid, tx_data, halt, halt_code
  );

  modport slave (
    input  we, a, wd, tx_ready,
    output rd, tx_valid, tx_data, halt, halt_code
  );
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory responder. Word RAM for a[31]=0, MMIO window for
// a[31]=1 (CYCLE, TXDATA, STATUS, HALT decoded on a[4:2]).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus (slave)  we/a/wd store port, rd combinational load data,
//                tx_valid/tx_data/tx_ready byte stream, halt/halt_code
// Optional feature: define DMEM_MMIO_CYCLE_EN to build the 32-bit CYCLE
// counter; otherwise CYCLE reads return 0 and no counter flops exist.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mmio_if.slave  bus
);

  localparam int unsigned RAW = $clog2(RAM_WORDS);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;

  localparam logic [2:0] OFF_CYCLE  = 3'd0;
  localparam logic [2:0] OFF_TXDATA = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_HALT   = 3'd3;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fmem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          halt_q;
  logic [31:0]   halt_code_q;
  logic [31:0]   cycle_val;

  logic [RAW-1:0] ram_idx;
  logic [2:0]     off;
  logic           is_mmio;
  logic           st_tx, st_status, st_halt;
  logic           empty, full, pop, push_ok;
  logic [31:0]    status_val;
  logic           unused_addr;

  // Decode
  assign ram_idx   = bus.a[RAW+1:2];
  assign off       = bus.a[4:2];
  assign is_mmio   = bus.a[31];
  assign st_tx     = bus.we & is_mmio & (off == OFF_TXDATA);
  assign st_status = bus.we & is_mmio & (off == OFF_STATUS);
  assign st_halt   = bus.we & is_mmio & (off == OFF_HALT);
  assign unused_addr = ^bus.a;

  // FIFO handshake; a full FIFO still accepts a push when the head pops
  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = ~empty & bus.tx_ready;
  assign push_ok = st_tx & (~full | pop);

  assign status_val = {24'b0, 4'(count), 1'b0, ovf, full, empty};

  // RAM: not reset, contents survive reset
  always_ff @(posedge clk) begin
    if (bus.we && !is_mmio) ram[ram_idx] <= bus.wd;
  end

  // FIFO storage: contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_ok) fmem[wr_ptr] <= bus.wd[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; TXDATA and STATUS stores are mutually exclusive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (st_status) begin
      ovf <= 1'b0;
    end else if (st_tx && !push_ok) begin
      ovf <= 1'b1;
    end
  end

  // First HALT store wins; later ones are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else if (st_halt && !halt_q) begin
      halt_q      <= 1'b1;
      halt_code_q <= bus.wd;
    end
  end

`ifdef DMEM_MMIO_CYCLE_EN
  // Free-running edge counter since reset release
  logic [31:0] cycle_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end
  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // Combinational load path
  always_comb begin
    bus.rd = '0;
    if (!is_mmio) begin
      bus.rd = ram[ram_idx];
    end else begin
      unique case (off)
        OFF_CYCLE:  bus.rd = cycle_val;
        OFF_STATUS: bus.rd = status_val;
        OFF_HALT:   bus.rd = halt_code_q;
        default:    bus.rd = '0;
      endcase
    end
  end

  assign bus.tx_valid  = ~empty;
  assign bus.tx_data   = fmem[rd_ptr];
  assign bus.halt      = halt_q;
  assign bus.halt_code = halt_code_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed test-plan steps followed by randomized traffic, all
// checked against a queue/array reference model of the responder.
module tb_dmem_mmio;
  localparam int unsigned RW = 64;
  localparam int unsigned FD = 4;
  localparam int unsigned IW = $clog2(RW);

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_HALT   = 32'h8000_000C;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_mmio_if bus();

  dmem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model
  logic [31:0] m_ram [RW];
  bit          m_ok  [RW];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  bit          m_halt;
  logic [31:0] m_code;
  logic [31:0] m_cyc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return {24'b0, 4'(n), 1'b0, m_ovf, (n == int'(FD)), (n == 0)};
  endfunction

  function automatic logic [31:0] m_cycle();
`ifdef DMEM_MMIO_CYCLE_EN
    return m_cyc;
`else
    return 32'd0;
`endif
  endfunction

  function automatic void m_load(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v = 32'd0;
    if (!a[31]) begin
      known = m_ok[a[IW+1:2]];
      v     = m_ram[a[IW+1:2]];
    end else begin
      case (a[4:2])
        3'd0: v = m_cycle();
        3'd2: v = m_status();
        3'd3: v = m_code;
        default: v = 32'd0;
      endcase
    end
  endfunction

  function automatic void m_edge(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    int off = int'(a[4:2]);
    bit mm  = a[31];
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (we && mm && off == 1) begin
      if (m_q.size() < int'(FD)) m_q.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    if (we && mm && off == 2) m_ovf = 1'b0;
    if (we && mm && off == 3 && !m_halt) begin
      m_halt = 1'b1;
      m_code = wd;
    end
    if (we && !mm) begin
      m_ram[a[IW+1:2]] = wd;
      m_ok[a[IW+1:2]]  = 1'b1;
    end
    m_cyc = m_cyc + 32'd1;
  endfunction

  // One clock cycle starting and ending at a negedge; checks pre-edge outputs
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, output logic [31:0] rdv);
    logic [31:0] e;
    bit known;
    bus.we = we; bus.a = a; bus.wd = wd; bus.tx_ready = rdy;
    #1;
    rdv = bus.rd;
    m_load(a, e, known);
    if (known) check("rd", bus.rd, e);
    check("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
    check("halt", 32'(bus.halt), 32'(m_halt));
    check("halt_code", bus.halt_code, m_code);
    @(posedge clk);
    m_edge(we, a, wd, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.we = 1'b0; bus.a = A_STATUS; bus.wd = '0; bus.tx_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_halt", 32'(bus.halt), 32'd0);
    check("rst_halt_code", bus.halt_code, 32'd0);
    check("rst_status", bus.rd, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_q.delete();
    m_ovf = 1'b0; m_halt = 1'b0; m_code = '0; m_cyc = '0;
  endtask

  initial begin
    logic [31:0] r, c1, c2, a;
    bus.we = 1'b0; bus.a = '0; bus.wd = '0; bus.tx_ready = 1'b0;
    reset = 1'b1;
    foreach (m_ok[i]) m_ok[i] = 1'b0;
    @(negedge clk);
    do_reset();

    // RAM store, load, alias
    step(1'b1, 32'h0000_0064, 32'd25, 1'b0, r);
    step(1'b0, 32'h0000_0064, 32'd0, 1'b0, r);
    check("ram_load", r, 32'd25);
    step(1'b0, 32'h0000_0164, 32'd0, 1'b0, r);
    check("ram_alias", r, 32'd25);

    // FIFO fill, overflow, drain
    for (int i = 0; i < 4; i++) step(1'b1, A_TXDATA, 32'h41 + 32'(i), 1'b0, r);
    step(1'b0, A_STATUS, 32'd0, 1'b0, r);
    check("status_full", r, 32'h42);
    step(1'b1, A_TXDATA, 32'h45, 1'b0, r);
    step(1'b0, A_STATUS, 32'd0, 1'b0, r);
    check("status_ovf", r, 32'h46);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(bus.tx_data), 32'h41 + 32'(i));
      step(1'b0, A_CYCLE, 32'd0, 1'b1, r);
    end
    check("drain_empty", 32'(bus.tx_valid), 32'd0);

    // Overflow clear keeps FIFO contents
    step(1'b1, A_TXDATA, 32'h11, 1'b0, r);
    step(1'b0, A_STATUS, 32'd0, 1'b0, r);
    check("status_ovf_one", r, 32'h14);
    step(1'b1, A_STATUS, 32'd0, 1'b0, r);
    step(1'b0, A_STATUS, 32'd0, 1'b0, r);
    check("status_ovf_clr", r, 32'h10);
    check("ovf_clr_data", 32'(bus.tx_data), 32'h11);
    step(1'b0, A_CYCLE, 32'd0, 1'b1, r);

    // Full FIFO with simultaneous pop accepts the push
    for (int i = 0; i < 4; i++) step(1'b1, A_TXDATA, 32'h51 + 32'(i), 1'b0, r);
    step(1'b1, A_TXDATA, 32'h55, 1'b1, r);
    step(1'b0, A_STATUS, 32'd0, 1'b0, r);
    check("full_pop_status", r, 32'h42);
    for (int i = 0; i < 4; i++) begin
      check("full_pop_data", 32'(bus.tx_data), 32'h52 + 32'(i));
      step(1'b0, A_CYCLE, 32'd0, 1'b1, r);
    end
    check("full_pop_empty", 32'(bus.tx_valid), 32'd0);

    // Halt is sticky
    step(1'b1, A_HALT, 32'd1, 1'b0, r);
    check("halt_set", 32'(bus.halt), 32'd1);
    step(1'b1, A_HALT, 32'd2, 1'b0, r);
    step(1'b0, A_HALT, 32'd0, 1'b0, r);
    check("halt_code_kept", r, 32'd1);

    // Cycle counter over 10 edges
    step(1'b0, A_CYCLE, 32'd0, 1'b0, c1);
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0000_0064, 32'd0, 1'b0, r);
    step(1'b1, A_CYCLE, 32'hFFFF_FFFF, 1'b0, c2);
`ifdef DMEM_MMIO_CYCLE_EN
    check("cycle_delta", c2 - c1, 32'd10);
`else
    check("cycle_zero_a", c1, 32'd0);
    check("cycle_zero_b", c2, 32'd0);
`endif

    // Reset mid-operation with bytes queued; RAM survives
    step(1'b1, A_TXDATA, 32'h77, 1'b0, r);
    do_reset();
    step(1'b0, 32'h0000_0064, 32'd0, 1'b0, r);
    check("ram_after_reset", r, 32'd25);
    step(1'b0, A_CYCLE, 32'd0, 1'b0, r);
    check("cycle_after_reset", r, m_cycle());

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int sel = int'($urandom_range(0, 9));
      if (sel < 3) begin
        a = {1'b0, 31'($urandom())};
      end else if (sel < 7) begin
        a = {1'b1, 26'($urandom()), 3'd1, 2'($urandom())};
      end else begin
        a = {1'b1, 26'($urandom()), 3'($urandom_range(0, 7)), 2'($urandom())};
      end
      step(1'($urandom_range(0, 1)), a, $urandom(), ($urandom_range(0, 3) == 0), r);
      if (i == 300) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the pipelined RISC-V core: answers the core's Memory-stage load/store port with word RAM plus a small memory-mapped I/O window. The window holds a free-running cycle counter, a byte transmit FIFO with a valid/ready output stream, and a sticky halt/result register. It replaces the plain data memory in `top` and gives software a way to emit bytes and signal pass/fail without address-snooping in the bench.

## Interface

Parameters:
- RAM_WORDS, 64: number of 32-bit RAM words. Must be a power of two.
- FIFO_DEPTH, 4: number of TX FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- we  in  1  store strobe from the core (MemWriteM)
- a  in  32  byte address (ALUResultM)
- wd  in  32  store data (WriteDataM)
- rd  out  32  load data (ReadDataM); combinational from a
- tx_valid  out  1  FIFO head byte is available
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer accepts the head byte this cycle
- halt  out  1  sticky; set by a store to HALT
- halt_code  out  32  value stored to HALT

## Operation

- Address decode uses a[31]. When a[31]=0, the access goes to RAM. When a[31]=1, it goes to MMIO.
- a[1:0] are ignored everywhere. Accesses are word only.
- RAM:
  - Index is a[log2(RAM_WORDS)+1:2]. Upper bits alias.
  - Read is combinational. Write happens on the posedge when we=1.
  - RAM is not reset.
- MMIO registers, decoded on a[4:2] with a[30:5] ignored:
  - 0x8000_0000 CYCLE: read-only cycle count. Stores are ignored.
  - 0x8000_0004 TXDATA: a store pushes wd[7:0] into the FIFO. Reads return 0.
  - 0x8000_0008 STATUS: read value is {24'b0, count[3:0], 1'b0, ovf, full, empty}. Any store clears ovf.
  - 0x8000_000C HALT: a store sets halt=1 and halt_code=wd, but only if halt is currently 0. Once set, later stores are ignored. Reads return halt_code.
  - Offsets 0x10–0x1C: reads return 0, stores are ignored.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of log2(FIFO_DEPTH) bits each, plus count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
  - pop = tx_valid & tx_ready.
  - push_req = store to TXDATA.
  - The push is accepted if count<FIFO_DEPTH or pop occurs in the same cycle.
  - A rejected push drops the byte and sets ovf. ovf is sticky until a STATUS store.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
  - tx_valid = (count!=0). tx_data = mem[rd_ptr]. Both are independent of tx_ready; there is no combinational path from tx_ready to tx_valid.
  - empty = (count==0). full = (count==FIFO_DEPTH). STATUS reports count truncated to 4 bits.
- Reset mid-operation:
  - FIFO contents are discarded: count=0 and both pointers are 0.
  - ovf=0, halt=0, halt_code=0, CYCLE=0.
  - RAM contents are preserved.

## Timing

- Loads have zero-cycle latency: rd settles within the same cycle as a, matching the core's single-cycle M stage.
- Stores, FIFO push, ovf set/clear and halt set all take effect at the posedge where we=1.
- Reads in the following cycle see the new value.
- A STATUS read in the same cycle as a push shows the pre-push state.
- CYCLE:
  - Increments every posedge while not in reset and wraps at 2^32.
  - A read returns the pre-edge value.
  - CYCLE counts the edges since reset deasserted: the first edge after deassert yields 1.
- FIFO:
  - A byte pushed at edge N appears on tx_valid/tx_data after edge N, i.e. in cycle N+1, when the FIFO was empty.
  - A pop at edge N exposes the next entry in cycle N+1.
- Reset values:
  - rd follows the decode (RAM reads are X until written).
  - tx_valid=0, tx_data=don't-care, halt=0, halt_code=0.
- halt is registered and has no combinational path from we.

## Configuration

- DMEM_MMIO_CYCLE_EN:
  - Defined: the 32-bit CYCLE counter is implemented as described above.
  - Not defined: no counter flops exist and CYCLE reads return 0. Stores to CYCLE remain ignored.
  - All other registers behave identically in both cases.

## Test plan

- RAM path: store 25 to 0x64, then load 0x64 → rd=25. Load 0x164 → also 25 (alias with RAM_WORDS=64).
- FIFO fill with tx_ready=0:
  - Push 0x41, 0x42, 0x43, 0x44 → STATUS=0x42 (count=4, full=1).
  - A fifth push of 0x45 → STATUS=0x46 (ovf set) and the byte is dropped.
  - Raise tx_ready for 4 cycles → tx_data sequence 0x41, 0x42, 0x43, 0x44, then tx_valid=0.
- Full plus simultaneous pop: FIFO full with tx_ready=1, push 0x55 in the same cycle → accepted, count stays 4, ovf unchanged. 0x55 is emitted last.
- Overflow clear: with ovf=1, store 0 to STATUS → STATUS bit2=0 next cycle. FIFO contents are unchanged.
- Halt: store 0x1 to HALT → halt=1, halt_code=1. A later store of 0x2 → halt_code stays 1. Assert reset → halt=0, halt_code=0.
- Cycle counter:
  - With DMEM_MMIO_CYCLE_EN, load CYCLE at two points 10 edges apart → difference is 10.
  - Without the macro → both reads return 0.
